agu_issue_arbiter: RTL and testbench
====================================

# agu_issue_arbiter

Shares one MemAddrCalcUnit address-generation datapath between two memory issue ports: ports 0 and 1 carry load and store-address uops. The block arbitrates the two ports round-robin and drives the winning uop into the AGU. It captures the AGU result in a 2-entry ordered output queue toward the LSU and drops any uop killed by a branch mispredict or a pipeline flush. It sits between the memory issue slots and the LSU address input.

## Interface
Parameters:
- BR_W, 20: branch-mask width
- ROB_W, 7: ROB index width
- VA_W, 40: virtual address width seen by the LSU

Ports:
- clock  in  1  single clock domain
- reset  in  1  synchronous, active-low (0 = reset); sampled on clock rising edge
- req_valid[i]  in  1  issue port i (i=0,1) holds a uop
- req_ready[i]  out  1  port i uop consumed this cycle
- req_uop[i]  in  agu_uop_t  uopc[6:0], rob_idx, br_mask[BR_W-1:0], mem_size[1:0], imm[11:0]
- req_rs1[i]  in  64  base register value
- agu_valid  out  1  AGU input valid (granted uop present)
- agu_uop  out  agu_uop_t  granted uop
- agu_rs1  out  64  granted rs1 value
- agu_addr  in  VA_W  AGU computed address (combinational return)
- agu_mxcpt  in  1  AGU misaligned flag (combinational return)
- brupdate_resolve_mask  in  BR_W  resolved branches
- brupdate_mispredict_mask  in  BR_W  mispredicted branches
- flush  in  1  pipeline flush; kills everything held
- out_valid  out  1  LSU entry valid
- out_ready  in  1  LSU accepts head
- out_uop  out  agu_uop_t  head uop, with br_mask already cleared by resolve_mask
- out_addr  out  VA_W  head address
- out_mxcpt  out  1  head misaligned
- out_port  out  1  originating port of head

## Operation
- Arbiter:
  - Eligible when queue count < 2, counted before this cycle's pop; the full queue has no bypass.
  - Both ports valid: grant the port selected by rr_ptr. Only one valid: grant it.
  - On any grant, rr_ptr <= ~granted port.
  - req_ready[g] = 1 only for the granted port. The AGU inputs mirror that port combinationally.
- Kill on request: a granted uop with (br_mask & mispredict_mask) != 0, or granted while flush = 1, is consumed (req_ready = 1) but not enqueued. rr_ptr still advances.
- Enqueue: the uop is stored with br_mask & ~resolve_mask, plus agu_addr, agu_mxcpt and port.
- Queue:
  - Two ordered slots, q0 = head. Each entry holds its own valid bit.
  - Every cycle each stored br_mask is ANDed with ~resolve_mask.
  - An entry whose mask hits mispredict_mask is dropped at the edge.
  - Survivors compact toward q0 with relative order preserved, then the new entry is appended.
- Output:
  - out_valid = q0.valid & ((q0.br_mask & mispredict_mask) == 0) & ~flush.
  - A pop happens when out_valid & out_ready.
- Flush clears both slots at the edge. Any same-cycle grant is consumed and dropped.
- Resolve and mispredict masks arriving in the same cycle apply kill first; the resolve clear applies only to survivors.

## Timing
- Reset values: out_valid 0, req_ready 0, agu_valid 0, count 0, rr_ptr 0 (port 0 first); all stored fields 0.
- Latency:
  - Grant in cycle N gives out_valid in N+1 with that entry, if the queue was empty.
  - AGU path is fully combinational within cycle N.
- Throughput: 1 uop/cycle when the LSU pops every cycle.
- Count 2 with a pop in cycle N: no grant in N; grant resumes in N+1.
- Count 1 with pop and grant in the same cycle: count stays 1, and the new entry becomes head.
- Reset asserted mid-operation: all state returns to reset values at the next edge. Held uops are discarded without a req_ready.

## Structure
- agu_arb_pkg holds:
  - agu_uop_t
  - UOPC_LD = 7'h1, UOPC_STA = 7'h2, UOPC_AMO_AG = 7'h43
  - default widths
- Sub-module rr_arb2: 2-way round-robin arbiter with pointer register, grant one-hot and advance-on-grant.
- The queue with kill/compaction stays in the top module.

## Test plan
- Both ports valid for 4 cycles, out_ready = 1: grants go 0,1,0,1; out_port sequence 0,1,0,1, each one cycle after its grant.
- out_ready = 0 with 3 uops offered: the first two enqueue and the third is stalled (req_ready = 0). out_ready = 1 next cycle: the third is granted in the following cycle.
- Queue holds A (br_mask 0x1) and B (br_mask 0x2); mispredict_mask = 0x1: out_valid drops to 0 that cycle; next cycle B is head with out_valid = 1.
- Grant of uop with br_mask 0x4 while mispredict_mask = 0x4: req_ready = 1 and the queue count is unchanged.
- rs1 = 0x1001, imm = 0, mem_size = 2, AGU returns mxcpt = 1: the entry presents out_mxcpt = 1 and out_addr = 0x1001.
- flush = 1 with 2 entries queued plus a new grant: next cycle out_valid = 0 and count = 0. Reset driven low mid-stream likewise gives out_valid = 0 and rr_ptr = 0.

Source files
------------

// File: rtl/agu_arb_pkg.sv
// Shared types and constants for the AGU issue arbiter: the uop word carried
// from the memory issue slots through the AGU into the LSU queue.
package agu_arb_pkg;

  localparam int AGU_BR_W  = 20;
  localparam int AGU_ROB_W = 7;
  localparam int AGU_VA_W  = 40;

  localparam logic [6:0] UOPC_LD     = 7'h01;
  localparam logic [6:0] UOPC_STA    = 7'h02;
  localparam logic [6:0] UOPC_AMO_AG = 7'h43;

  typedef struct packed {
    logic [6:0]           uopc;
    logic [AGU_ROB_W-1:0] rob_idx;
    logic [AGU_BR_W-1:0]  br_mask;
    logic [1:0]           mem_size;
    logic [11:0]          imm;
  } agu_uop_t;

endpackage

// File: rtl/agu_issue_arbiter_if.sv
// Bundle of issue-port, AGU, branch-update and LSU-side signals around the
// arbiter, plus debug taps of the queue occupancy and round-robin pointer.
interface agu_issue_arbiter_if
  import agu_arb_pkg::*;
#(
  parameter int BR_W = AGU_BR_W,
  parameter int VA_W = AGU_VA_W
);
  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid never depends on ready, and ready may depend on valid.
  logic [1:0]      req_valid;
  logic [1:0]      req_ready;
  agu_uop_t        req_uop [2];
  logic [63:0]     req_rs1 [2];

  logic            agu_valid;
  agu_uop_t        agu_uop;
  logic [63:0]     agu_rs1;
  logic [VA_W-1:0] agu_addr;
  logic            agu_mxcpt;

  logic [BR_W-1:0] brupdate_resolve_mask;
  logic [BR_W-1:0] brupdate_mispredict_mask;
  logic            flush;

  logic            out_valid;
  logic            out_ready;
  agu_uop_t        out_uop;
  logic [VA_W-1:0] out_addr;
  logic            out_mxcpt;
  logic            out_port;

  logic [1:0]      dbg_count;
  logic            dbg_rr_ptr;

  modport master (
    output req_valid, req_uop, req_rs1, agu_addr, agu_mxcpt,
           brupdate_resolve_mask, brupdate_mispredict_mask, flush, out_ready,
    input  req_ready, agu_valid, agu_uop, agu_rs1, out_valid, out_uop,
           out_addr, out_mxcpt, out_port, dbg_count, dbg_rr_ptr
  );

  modport slave (
    input  req_valid, req_uop, req_rs1, agu_addr, agu_mxcpt,
           brupdate_resolve_mask, brupdate_mispredict_mask, flush, out_ready,
    output req_ready, agu_valid, agu_uop, agu_rs1, out_valid, out_uop,
           out_addr, out_mxcpt, out_port, dbg_count, dbg_rr_ptr
  );
endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the pointer names the favoured port and moves
// to the other port whenever a grant is issued.
module rr_arb2 (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt,
  output logic       rr_ptr
);

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      if (req == 2'b11) gnt = rr_ptr ? 2'b10 : 2'b01;
      else              gnt = req;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset)      rr_ptr <= 1'b0;
    else if (|gnt)   rr_ptr <= gnt[0];
  end

endmodule

// File: rtl/agu_issue_arbiter.sv
// Shares one AGU between two memory issue ports and buffers AGU results in a
// two-entry ordered queue toward the LSU, dropping mispredicted/flushed uops.
module agu_issue_arbiter
  import agu_arb_pkg::*;
#(
  parameter int BR_W  = AGU_BR_W,
  parameter int ROB_W = AGU_ROB_W,
  parameter int VA_W  = AGU_VA_W
) (
  input  logic               clock,
  input  logic               reset,
  agu_issue_arbiter_if.slave bus
);

  localparam int UOP_W = 7 + ROB_W + BR_W + 2 + 12;

  typedef struct packed {
    logic             valid;
    logic [UOP_W-1:0] uop;
    logic [VA_W-1:0]  addr;
    logic             mxcpt;
    logic             port;
  } q_ent_t;

  q_ent_t     q     [2];
  q_ent_t     q_nxt [2];
  q_ent_t     new_ent;
  agu_uop_t   gnt_uop;
  agu_uop_t   head_uop;
  logic [1:0] gnt;
  logic       rr_ptr;
  logic       gsel;
  logic       eligible;
  logic       req_killed;
  logic       enq;
  logic [1:0] live;
  logic       pop;
  logic       keep0;
  logic       keep1;

  function automatic q_ent_t resolve_clear(input q_ent_t e, input logic [BR_W-1:0] res);
    agu_uop_t u;
    u         = agu_uop_t'(e.uop);
    u.br_mask = u.br_mask & ~res;
    e.uop     = u;
    return e;
  endfunction

  function automatic logic br_hit(input logic [UOP_W-1:0] uop_bits, input logic [BR_W-1:0] mis);
    agu_uop_t u;
    u = agu_uop_t'(uop_bits);
    return |(u.br_mask & mis);
  endfunction

  // A full queue blocks grants even if the head pops this cycle.
  assign eligible = ~(q[0].valid & q[1].valid) & reset;

  rr_arb2 u_arb (
    .clock  (clock),
    .reset  (reset),
    .req    (bus.req_valid),
    .en     (eligible),
    .gnt    (gnt),
    .rr_ptr (rr_ptr)
  );

  assign gsel       = gnt[1];
  assign gnt_uop    = bus.req_uop[gsel];
  assign req_killed = bus.flush | (|(gnt_uop.br_mask & bus.brupdate_mispredict_mask));
  assign enq        = (|gnt) & ~req_killed;

  always_comb begin
    agu_uop_t u;
    u               = gnt_uop;
    u.br_mask       = u.br_mask & ~bus.brupdate_resolve_mask;
    new_ent.valid   = 1'b1;
    new_ent.uop     = u;
    new_ent.addr    = bus.agu_addr;
    new_ent.mxcpt   = bus.agu_mxcpt;
    new_ent.port    = gsel;
  end

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      live[i] = q[i].valid & ~br_hit(q[i].uop, bus.brupdate_mispredict_mask) & ~bus.flush;
    end
  end

  assign pop   = live[0] & bus.out_ready;
  assign keep0 = live[0] & ~pop;
  assign keep1 = live[1];

  // Survivors slide toward slot 0 in order; the new entry lands behind them.
  always_comb begin
    q_nxt[0]       = q[0];
    q_nxt[0].valid = 1'b0;
    q_nxt[1]       = q[1];
    q_nxt[1].valid = 1'b0;
    if (keep0 && keep1) begin
      q_nxt[0] = resolve_clear(q[0], bus.brupdate_resolve_mask);
      q_nxt[1] = resolve_clear(q[1], bus.brupdate_resolve_mask);
    end else if (keep0 || keep1) begin
      q_nxt[0] = resolve_clear(keep0 ? q[0] : q[1], bus.brupdate_resolve_mask);
      if (enq) q_nxt[1] = new_ent;
    end else if (enq) begin
      q_nxt[0] = new_ent;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      q[0] <= '0;
      q[1] <= '0;
    end else begin
      q[0] <= q_nxt[0];
      q[1] <= q_nxt[1];
    end
  end

  always_comb begin
    head_uop         = agu_uop_t'(q[0].uop);
    head_uop.br_mask = head_uop.br_mask & ~bus.brupdate_resolve_mask;
  end

  assign bus.req_ready  = gnt;
  assign bus.agu_valid  = |gnt;
  assign bus.agu_uop    = gnt_uop;
  assign bus.agu_rs1    = bus.req_rs1[gsel];
  assign bus.out_valid  = live[0];
  assign bus.out_uop    = head_uop;
  assign bus.out_addr   = q[0].addr;
  assign bus.out_mxcpt  = q[0].mxcpt;
  assign bus.out_port   = q[0].port;
  assign bus.dbg_count  = {1'b0, q[0].valid} + {1'b0, q[1].valid};
  assign bus.dbg_rr_ptr = rr_ptr;

endmodule

// File: tb/tb_agu_issue_arbiter.sv
// Directed bench for agu_issue_arbiter with a behavioural AGU (rs1 + sext(imm),
// misaligned when the address is not a multiple of the access size).
module tb_agu_issue_arbiter;
  import agu_arb_pkg::*;

  localparam int BR_W = 20;
  localparam int VA_W = 40;

  logic clk;
  logic reset;
  int   total;
  int   bad;
  logic [0:0] exp_q[$];

  agu_issue_arbiter_if #(.BR_W(BR_W), .VA_W(VA_W)) bus ();

  agu_issue_arbiter dut (
    .clock (clk),
    .reset (reset),
    .bus   (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    logic [VA_W-1:0] a;
    logic [VA_W-1:0] m;
    a             = bus.agu_rs1[VA_W-1:0] + {{(VA_W-12){bus.agu_uop.imm[11]}}, bus.agu_uop.imm};
    m             = (VA_W'(1) << bus.agu_uop.mem_size) - VA_W'(1);
    bus.agu_addr  = a;
    bus.agu_mxcpt = |(a & m);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic next_cycle();
    @(negedge clk);
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_uop(input int p, input logic [6:0] uopc, input logic [BR_W-1:0] br,
                         input logic [1:0] size, input logic [11:0] imm, input logic [63:0] rs1);
    agu_uop_t u;
    u.uopc       = uopc;
    u.rob_idx    = 7'(p + 3);
    u.br_mask    = br;
    u.mem_size   = size;
    u.imm        = imm;
    bus.req_uop[p] = u;
    bus.req_rs1[p] = rs1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b0;
    bus.req_valid = 2'b00;
    bus.brupdate_resolve_mask    = '0;
    bus.brupdate_mispredict_mask = '0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    set_uop(0, UOPC_LD, '0, 2'd0, 12'h0, 64'h100);
    set_uop(1, UOPC_STA, '0, 2'd0, 12'h0, 64'h200);

    // reset: uops offered but never consumed
    next_cycle(); bus.req_valid = 2'b11; settle();
    check("rst_req_ready", 64'(bus.req_ready), 64'h0);
    check("rst_agu_valid", 64'(bus.agu_valid), 64'h0);
    next_cycle(); settle();
    check("rst_out_valid", 64'(bus.out_valid), 64'h0);
    check("rst_count", 64'(bus.dbg_count), 64'h0);
    check("rst_rr_ptr", 64'(bus.dbg_rr_ptr), 64'h0);
    next_cycle(); reset = 1'b1; bus.req_valid = 2'b00; bus.out_ready = 1'b1;

    // round robin with both ports always valid
    for (int i = 0; i < 5; i++) begin
      next_cycle();
      bus.req_valid = (i < 4) ? 2'b11 : 2'b00;
      settle();
      if (i < 4) check("rr_grant", 64'(bus.req_ready), (i % 2 == 1) ? 64'h2 : 64'h1);
      if (i > 0) begin
        check("rr_out_valid", 64'(bus.out_valid), 64'h1);
        check("rr_out_port", 64'(bus.out_port), 64'(exp_q.pop_front()));
        check("rr_out_addr", 64'(bus.out_addr), (i % 2 == 1) ? 64'h100 : 64'h200);
      end
      if (i < 4) exp_q.push_back(1'(i % 2));
    end
    next_cycle(); settle();
    check("rr_drained", 64'(bus.out_valid), 64'h0);

    // full queue stalls the third uop until a pop has landed
    bus.out_ready = 1'b0;
    set_uop(0, UOPC_LD, '0, 2'd0, 12'h0, 64'h300);
    set_uop(1, UOPC_STA, '0, 2'd0, 12'h0, 64'h400);
    bus.req_valid = 2'b11; settle();
    check("full_g0", 64'(bus.req_ready), 64'h1);
    next_cycle(); settle();
    check("full_g1", 64'(bus.req_ready), 64'h2);
    check("full_head", 64'(bus.out_addr), 64'h300);
    next_cycle(); bus.req_valid = 2'b01; set_uop(0, UOPC_LD, '0, 2'd0, 12'h0, 64'h500); settle();
    check("full_stall", 64'(bus.req_ready), 64'h0);
    check("full_count", 64'(bus.dbg_count), 64'h2);
    next_cycle(); bus.out_ready = 1'b1; settle();
    check("full_no_bypass", 64'(bus.req_ready), 64'h0);
    check("full_pop_port", 64'(bus.out_port), 64'h0);
    next_cycle(); settle();
    check("full_resume", 64'(bus.req_ready), 64'h1);
    check("full_head2", 64'(bus.out_addr), 64'h400);
    next_cycle(); bus.req_valid = 2'b00; settle();
    check("pop_grant_count", 64'(bus.dbg_count), 64'h1);
    check("pop_grant_head", 64'(bus.out_addr), 64'h500);
    next_cycle(); settle();
    check("full_empty", 64'(bus.dbg_count), 64'h0);

    // mispredict drops the head; the younger entry compacts to slot 0
    bus.out_ready = 1'b0;
    set_uop(1, UOPC_LD, 20'h1, 2'd0, 12'h0, 64'h600);
    bus.req_valid = 2'b10; settle();
    check("kq_gA", 64'(bus.req_ready), 64'h2);
    next_cycle(); set_uop(0, UOPC_STA, 20'h2, 2'd0, 12'h0, 64'h700); bus.req_valid = 2'b01; settle();
    check("kq_gB", 64'(bus.req_ready), 64'h1);
    next_cycle(); bus.req_valid = 2'b00; settle();
    check("kq_count", 64'(bus.dbg_count), 64'h2);
    check("kq_valid_pre", 64'(bus.out_valid), 64'h1);
    bus.brupdate_mispredict_mask = 20'h1; settle();
    check("kq_valid_kill", 64'(bus.out_valid), 64'h0);
    next_cycle(); bus.brupdate_mispredict_mask = '0; settle();
    check("kq_valid_B", 64'(bus.out_valid), 64'h1);
    check("kq_addr_B", 64'(bus.out_addr), 64'h700);
    check("kq_port_B", 64'(bus.out_port), 64'h0);
    check("kq_count_B", 64'(bus.dbg_count), 64'h1);
    check("kq_mask_B", 64'(bus.out_uop.br_mask), 64'h2);
    next_cycle(); bus.brupdate_resolve_mask = 20'h2;
    next_cycle(); bus.brupdate_resolve_mask = '0; bus.brupdate_mispredict_mask = 20'h2;
    bus.out_ready = 1'b1; settle();
    check("res_survive", 64'(bus.out_valid), 64'h1);
    check("res_mask", 64'(bus.out_uop.br_mask), 64'h0);
    next_cycle(); bus.brupdate_mispredict_mask = '0; bus.out_ready = 1'b0; settle();
    check("res_popped", 64'(bus.dbg_count), 64'h0);

    // uop killed at grant: consumed, not queued, pointer still moves
    set_uop(1, UOPC_LD, 20'h4, 2'd0, 12'h0, 64'h900);
    bus.brupdate_mispredict_mask = 20'h4; bus.req_valid = 2'b10; settle();
    check("kg_ready", 64'(bus.req_ready), 64'h2);
    next_cycle(); bus.req_valid = 2'b00; bus.brupdate_mispredict_mask = '0; settle();
    check("kg_count", 64'(bus.dbg_count), 64'h0);
    check("kg_out_valid", 64'(bus.out_valid), 64'h0);
    check("kg_rr_ptr", 64'(bus.dbg_rr_ptr), 64'h0);

    // misaligned word access, then flush of a full queue and of a new grant
    set_uop(1, UOPC_STA, '0, 2'd2, 12'h0, 64'h1001);
    bus.req_valid = 2'b10; settle();
    check("mx_agu_valid", 64'(bus.agu_valid), 64'h1);
    check("mx_agu_rs1", 64'(bus.agu_rs1), 64'h1001);
    next_cycle(); set_uop(0, UOPC_LD, '0, 2'd3, 12'h10, 64'h800); bus.req_valid = 2'b01; settle();
    check("mx_out_valid", 64'(bus.out_valid), 64'h1);
    check("mx_out_addr", 64'(bus.out_addr), 64'h1001);
    check("mx_out_mxcpt", 64'(bus.out_mxcpt), 64'h1);
    check("mx_out_port", 64'(bus.out_port), 64'h1);
    check("mx_out_uopc", 64'(bus.out_uop.uopc), 64'(UOPC_STA));
    check("mx_second_grant", 64'(bus.req_ready), 64'h1);
    next_cycle(); bus.req_valid = 2'b00; bus.flush = 1'b1; settle();
    check("fl_count_pre", 64'(bus.dbg_count), 64'h2);
    check("fl_out_valid", 64'(bus.out_valid), 64'h0);
    next_cycle(); bus.req_valid = 2'b10; settle();
    check("fl_count", 64'(bus.dbg_count), 64'h0);
    check("fl_grant_consumed", 64'(bus.req_ready), 64'h2);
    next_cycle(); bus.req_valid = 2'b00; bus.flush = 1'b0; settle();
    check("fl_grant_dropped", 64'(bus.dbg_count), 64'h0);
    check("fl_out_valid2", 64'(bus.out_valid), 64'h0);
    check("fl_rr_ptr", 64'(bus.dbg_rr_ptr), 64'h0);

    // reset mid-stream
    bus.req_valid = 2'b01; settle();
    check("mr_grant", 64'(bus.req_ready), 64'h1);
    next_cycle(); bus.req_valid = 2'b11; reset = 1'b0; settle();
    check("mr_no_ready", 64'(bus.req_ready), 64'h0);
    check("mr_no_agu", 64'(bus.agu_valid), 64'h0);
    check("mr_held_valid", 64'(bus.out_valid), 64'h1);
    check("mr_ptr_pre", 64'(bus.dbg_rr_ptr), 64'h1);
    next_cycle(); reset = 1'b1; bus.req_valid = 2'b00; settle();
    check("mr_out_valid", 64'(bus.out_valid), 64'h0);
    check("mr_count", 64'(bus.dbg_count), 64'h0);
    check("mr_rr_ptr", 64'(bus.dbg_rr_ptr), 64'h0);

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
